// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, word geometry and default widths for mem_responder
package mem_pkg;
  localparam int DATA_W_DEF      = 32;
  localparam int DEPTH_LOG2_DEF  = 8;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int ADDR_W          = 32;
  localparam int WORD_BYTES      = 4;
  localparam int OFF_W           = $clog2(WORD_BYTES);
  localparam int CNT_W           = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU-side request/response bundle of the memory responder
// master drives enable/mem_read/mem_write/addr/write_data; slave drives read_data/mem_ready/busy/error
interface mem_responder_if #(parameter int DATA_W = mem_pkg::DATA_W_DEF);
  logic                      enable;
  logic                      mem_read;
  logic                      mem_write;
  logic [mem_pkg::ADDR_W-1:0] addr;
  logic [DATA_W-1:0]         write_data;
  logic [DATA_W-1:0]         read_data;
  logic                      mem_ready;
  logic                      busy;
  logic                      error;
  modport master (output enable, mem_read, mem_write, addr, write_data,
                  input  read_data, mem_ready, busy, error);
  modport slave  (input  enable, mem_read, mem_write, addr, write_data,
                  output read_data, mem_ready, busy, error);
endinterface

// File: rtl/mem_array.sv
// mem_array: word storage with synchronous write and asynchronous read, no reset
// clk: write clock; we/addr/wdata: write port; rdata: combinational read of addr
module mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for a multi-cycle CPU core
// clk, rst_n (async, active-low); bus: slave side of mem_responder_if
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic                  accept, we;
  logic [DATA_W-1:0]     rdata;
  logic                  unused_addr_hi;

  // address bits above the word index wrap silently
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:OFF_W+DEPTH_LOG2];
  assign accept = (state_q == IDLE) & bus.enable & (bus.mem_read | bus.mem_write);

  mem_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        idx_d   = bus.addr[OFF_W +: DEPTH_LOG2];
        wdata_d = bus.write_data;
        rd_d    = bus.mem_read;
        wr_d    = bus.mem_write;
        // conflicting or misaligned requests are answered but never touch memory
        err_d   = (bus.mem_read & bus.mem_write) | (|bus.addr[OFF_W-1:0]);
      end
      WAIT: if (bus.enable) begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? RESP : WAIT;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_ready = state_q == RESP;
    bus.busy      = state_q != IDLE;
    bus.error     = bus.mem_ready & err_q;
    bus.read_data = (bus.mem_ready & rd_q & ~err_q) ? rdata : '0;
    we            = bus.mem_ready & wr_q & ~err_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a word-level model
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_mem [16];

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(32)) bus ();

  mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int stall, output logic [31:0] rdata, output logic err,
                        output int lat, output bit quiet_ok);
    int guard;
    logic [31:0] r;
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.addr = a;
    bus.write_data = d;
    bus.enable = 1'b1;
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    r = $urandom;
    bus.addr = r;
    r = $urandom;
    bus.write_data = r;
    quiet_ok = 1'b1;
    lat = -1;
    rdata = '0;
    err = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        lat = c;
        rdata = bus.read_data;
        err = bus.error;
        break;
      end
      if (bus.read_data !== 32'h0 || bus.error !== 1'b0 || bus.busy !== 1'b1) quiet_ok = 1'b0;
      bus.enable = (c <= stall) ? 1'b0 : 1'b1;
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr = '0;
    bus.write_data = '0;
    #12;
    n_checks++;
    if ({bus.busy, bus.mem_ready, bus.error} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/ready/error=%b want 000", {bus.busy, bus.mem_ready, bus.error});
    end
    n_checks++;
    if (bus.read_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", bus.read_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_preload();
    logic [31:0] rd, d;
    logic e;
    int lat;
    bit q;
    for (int i = 0; i < 16; i++) begin
      d = (i == 4) ? 32'hDEADBEEF : $urandom;
      do_req(1'b0, 1'b1, 32'(i * 4), d, 0, rd, e, lat, q);
      model_mem[i] = d;
      n_checks++;
      if (lat != 3 || e !== 1'b0 || rd !== 32'h0 || !q) begin
        n_fail++;
        $display("FAIL preload_w%0d: lat=%0d err=%b data=%h quiet=%0d want lat=3 err=0 data=0 quiet=1", i, lat, e, rd, q);
      end
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] rd;
    logic e;
    int lat;
    bit q;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 0, rd, e, lat, q);
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL read_latency: got %0d want 3", lat);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data: got %h err=%b want deadbeef err=0", rd, e);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.mem_ready, bus.read_data} !== 34'h0) begin
      n_fail++;
      $display("FAIL resp_one_cycle: busy=%b ready=%b data=%h want 0 0 0", bus.busy, bus.mem_ready, bus.read_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic e;
    int lat;
    bit q;
    do_req(1'b0, 1'b1, 32'h20, 32'h12345678, 0, rd, e, lat, q);
    model_mem[8] = 32'h12345678;
    n_checks++;
    if (lat != 3 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_write: lat=%0d err=%b want 3 0", lat, e);
    end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 0, rd, e, lat, q);
    n_checks++;
    if (lat != 3 || rd !== 32'h12345678 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read: lat=%0d data=%h err=%b want 3 12345678 0", lat, rd, e);
    end
  endtask

  task automatic test_enable_stall();
    logic [31:0] rd;
    logic e;
    int lat;
    bit q;
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 3, rd, e, lat, q);
    n_checks++;
    if (lat != 6 || !q) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d quiet=%0d want 6 quiet=1", lat, q);
    end
    n_checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_data: got %h err=%b want deadbeef 0", rd, e);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic e;
    int lat;
    bit q;
    do_req(1'b0, 1'b1, 32'h22, 32'hCAFEF00D, 0, rd, e, lat, q);
    n_checks++;
    if (lat != 3 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL misaligned: lat=%0d err=%b data=%h want 3 1 0", lat, e, rd);
    end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 0, rd, e, lat, q);
    n_checks++;
    if (rd !== model_mem[8] || e !== 1'b0) begin
      n_fail++;
      $display("FAIL misaligned_nowrite: got %h err=%b want %h 0", rd, e, model_mem[8]);
    end
    do_req(1'b1, 1'b1, 32'h20, 32'h0BAD0BAD, 0, rd, e, lat, q);
    n_checks++;
    if (lat != 3 || e !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL both_rw: lat=%0d err=%b data=%h want 3 1 0", lat, e, rd);
    end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 0, rd, e, lat, q);
    n_checks++;
    if (rd !== model_mem[8]) begin
      n_fail++;
      $display("FAIL both_rw_nowrite: got %h want %h", rd, model_mem[8]);
    end
    do_req(1'b1, 1'b0, 32'h410, 32'h0, 0, rd, e, lat, q);
    n_checks++;
    if (rd !== model_mem[4] || e !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_read: got %h err=%b want %h 0", rd, e, model_mem[4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic e;
    int lat;
    bit q;
    int guard;
    bus.mem_write = 1'b1;
    bus.addr = 32'h30;
    bus.write_data = ~model_mem[12];
    bus.enable = 1'b1;
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: got %b want 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.mem_ready, bus.error, bus.read_data} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b ready=%b err=%b data=%h want all 0", bus.busy, bus.mem_ready, bus.error, bus.read_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 0, rd, e, lat, q);
    n_checks++;
    if (rd !== model_mem[12] || lat != 3) begin
      n_fail++;
      $display("FAIL reset_mid_nowrite: got %h lat=%0d want %h lat=3", rd, lat, model_mem[12]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp_data;
    logic e;
    bit rq, wq, exp_err, q;
    int lat, st, k;
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      a[9:6] = 4'h0;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[1:0] = 2'b01;
      k = $urandom_range(0, 9);
      rq = (k < 5);
      wq = (k >= 5) || (k == 0);
      d = $urandom;
      st = $urandom_range(0, 3);
      exp_err = (rq && wq) || (a[1:0] != 2'b00);
      exp_data = (rq && !exp_err) ? model_mem[a[5:2]] : 32'h0;
      do_req(rq, wq, a, d, st, rd, e, lat, q);
      if (wq && !exp_err) model_mem[a[5:2]] = d;
      n_checks++;
      if (lat != 3 + st || e !== exp_err || rd !== exp_data || !q) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h rd=%0d wr=%0d lat=%0d err=%b data=%h quiet=%0d want lat=%0d err=%b data=%h quiet=1",
                 n, a, rq, wq, lat, e, rd, q, 3 + st, exp_err, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_basic();
    test_back_to_back();
    test_enable_stall();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits.
REQ-002 Parameter DEPTH_LOG2, default 8: log2 of memory depth in words (256 words).
REQ-003 Parameter WAIT_CYCLES, default 2: wait states inserted between request accept and response (0..15).
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Enable  input  1  global run enable; when 0, the block accepts no new request and freezes its wait counter.
REQ-007 MemRead  input  1  read request from the multi-cycle CPU core.
REQ-008 MemWrite  input  1  write request from the multi-cycle CPU core.
REQ-009 Addr  input  32  byte address; bits [1:0] must be 00, bits [DEPTH_LOG2+1:2] select the word.
REQ-010 WriteData  input  DATA_W  write data.
REQ-011 ReadData  output  DATA_W  read data; valid only while MemReady=1.
REQ-012 MemReady  output  1  one-cycle response strobe ending every accepted request.
REQ-013 Busy  output  1  high from accept until the cycle after MemReady.
REQ-014 Error  output  1  qualified by MemReady; marks a rejected request.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE: a request is accepted when Enable=1 and (MemRead or MemWrite)=1.
REQ-017 On accept, Addr, WriteData, MemRead and MemWrite are latched; later changes on these inputs are ignored until return to IDLE.
REQ-018 On accept, wait counter loads WAIT_CYCLES and the FSM enters WAIT, or enters RESP directly when WAIT_CYCLES=0.
REQ-019 WAIT: counter decrements by 1 per cycle only when Enable=1; when it reaches 1 with Enable=1, the FSM enters RESP next.
REQ-020 Latency: with Enable held at 1, MemReady asserts exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 RESP lasts exactly one cycle regardless of Enable; MemReady=1, then FSM returns to IDLE.
REQ-022 Back-to-back requests: a request present in the cycle after RESP is accepted; no request is accepted during RESP.
REQ-023 Read: ReadData = memory word at latched word index during RESP; 0 in all other cycles.
REQ-024 Write: memory word is updated on the RESP clock edge; ReadData=0 for writes.
REQ-025 MemRead and MemWrite both 1 at accept: no memory access, Error=1 with MemReady.
REQ-026 Latched Addr[1:0] != 00: no memory access, ReadData=0, Error=1 with MemReady.
REQ-027 Addr bits above DEPTH_LOG2+1 are ignored (address wraps modulo depth); no error.
REQ-028 Error=0 whenever MemReady=0.

Reset
REQ-029 Reset low asynchronously forces IDLE, counter=0, latched request cleared, MemReady=0, Busy=0, Error=0, ReadData=0.
REQ-030 Reset mid-operation aborts the request; a pending write is not committed.
REQ-031 Memory contents are not cleared by reset; preload occurs only through simulation initialisation.

Structure
REQ-032 Package mem_pkg holds the FSM state typedef (IDLE/WAIT/RESP), WORD_BYTES constant and the default widths.
REQ-033 Storage is one sub-module, mem_array: DEPTH words, synchronous write, asynchronous read, no reset.
REQ-034 FSM, counter and request latch reside in mem_responder; all outputs are registered or decoded from state only.

Verification
REQ-035 Preload word 4 = 0xDEADBEEF, WAIT_CYCLES=2, MemRead with Addr=0x10 -> MemReady one cycle, 3 cycles after accept, ReadData=0xDEADBEEF, Error=0.
REQ-036 MemWrite Addr=0x20 WriteData=0x12345678, then MemRead Addr=0x20 in the cycle after RESP -> ReadData=0x12345678.
REQ-037 Read Addr=0x10 with Enable dropped for 3 cycles during WAIT -> MemReady delayed by exactly 3 cycles, data unchanged.
REQ-038 MemWrite Addr=0x22 -> Error=1 with MemReady; read of 0x20 still returns prior value.
REQ-039 MemRead and MemWrite both 1 -> Error=1, memory unchanged; Addr=0x410 read returns word 4 (wrap).
REQ-040 Reset low during WAIT of a write to 0x30 -> outputs 0 immediately, later read of 0x30 returns pre-write value.
